pulse_train_generator: RTL and testbench

PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

---
 rtl/pulse_pkg.sv | 15 +
 rtl/pulse_train_generator_if.sv | 31 +++
 rtl/phase_timer.sv | 37 +++
 rtl/pulse_train_generator.sv | 147 ++++++++++++++
 tb/tb_pulse_train_generator.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse train generator.
// Holds the controller state encoding and the default field widths.
package pulse_pkg;

    localparam int PULSE_CW = 8;
    localparam int PULSE_NW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } pulse_state_t;

endpackage

// File: rtl/pulse_train_generator_if.sv
// Control and status bundle of the pulse train generator.
// The master side requests trains and the slave side (the generator) produces the waveform.
interface pulse_train_generator_if
    import pulse_pkg::*;
#(
    parameter int CW = PULSE_CW,
    parameter int NW = PULSE_NW
);

    logic          start;
    logic          abort;
    logic [CW-1:0] delay;
    logic [CW-1:0] high_len;
    logic [CW-1:0] low_len;
    logic [NW-1:0] num_pulses;
    logic          wave;
    logic          rise_strobe;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, delay, high_len, low_len, num_pulses,
        input  wave, rise_strobe, busy, done
    );

    modport slave (
        input  start, abort, delay, high_len, low_len, num_pulses,
        output wave, rise_strobe, busy, done
    );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter with a zero flag; times the DELAY, HIGH and LOW phases.
// A load of N keeps the flag low for N cycles and the count parks at zero.
module phase_timer
    import pulse_pkg::*;
#(
    parameter int CW = PULSE_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Generates a train of num_pulses pulses after an initial delay, with fixed high/low lengths.
// The configuration is captured at start acceptance; all outputs come straight from flops.
module pulse_train_generator
    import pulse_pkg::*;
#(
    parameter int CW = PULSE_CW,
    parameter int NW = PULSE_NW
) (
    input logic                    clk,
    input logic                    rst,
    pulse_train_generator_if.slave bus
);

    pulse_state_t  state_d, state_q;
    logic          wave_d, wave_q;
    logic          rise_d, rise_q;
    logic          busy_d, busy_q;
    logic          done_d, done_q;
    logic [CW-1:0] high_d, high_q;
    logic [CW-1:0] low_d, low_q;
    logic [NW-1:0] left_d, left_q;

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;
    logic [CW-1:0] high_m1;
    logic [CW-1:0] low_m1;

    // A phase of length L is loaded as L-1; a zero length behaves like one cycle.
    assign high_m1 = (high_q == '0) ? '0 : high_q - 1'b1;
    assign low_m1  = (low_q == '0) ? '0 : low_q - 1'b1;

    phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        wave_d   = wave_q;
        rise_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        high_d   = high_q;
        low_d    = low_q;
        left_d   = left_q;
        tmr_load = 1'b0;
        tmr_val  = high_m1;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d  = DELAY;
                    high_d   = bus.high_len;
                    low_d    = bus.low_len;
                    left_d   = bus.num_pulses;
                    busy_d   = (bus.num_pulses != '0);
                    tmr_load = 1'b1;
                    tmr_val  = bus.delay;
                end
            end
            DELAY: begin
                // An empty train still spends one cycle here so done lands one edge after acceptance.
                if (left_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (tmr_zero) begin
                    state_d  = HIGH;
                    wave_d   = 1'b1;
                    rise_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = high_m1;
                end
            end
            HIGH: begin
                if (tmr_zero) begin
                    wave_d = 1'b0;
                    if (left_q == NW'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = LOW;
                        left_d   = left_q - 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = low_m1;
                    end
                end
            end
            LOW: begin
                if (tmr_zero) begin
                    state_d  = HIGH;
                    wave_d   = 1'b1;
                    rise_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = high_m1;
                end
            end
            default: begin
                state_d = IDLE;
                wave_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (bus.abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            wave_d   = 1'b0;
            rise_d   = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            tmr_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wave_q  <= 1'b0;
            rise_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            high_q  <= '0;
            low_q   <= '0;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            wave_q  <= wave_d;
            rise_q  <= rise_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            high_q  <= high_d;
            low_q   <= low_d;
            left_q  <= left_d;
        end
    end

    assign bus.wave        = wave_q;
    assign bus.rise_strobe = rise_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for the pulse train generator against a timeline model of expected outputs.
// exp_*[t] holds the value each output must show in the cycle after rising edge number t.
module tb_pulse_train_generator;

    localparam int CW   = 8;
    localparam int NW   = 4;
    localparam int MAXC = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pulse_train_generator_if #(.CW(CW), .NW(NW)) bus ();

    pulse_train_generator #(.CW(CW), .NW(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    bit exp_wave [MAXC];
    bit exp_busy [MAXC];
    bit exp_done [MAXC];

    int cyc           = 0;
    int n_cmp         = 0;
    int n_fail        = 0;
    int dut_rise_cnt  = 0;
    int wave_edge_cnt = 0;
    int dut_done_cnt  = 0;
    int last_done_cyc = -1;
    logic prev_wave   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic apply_stimulus(input int d, input int h, input int l, input int n,
                                  input bit st, input bit ab);
        bus.delay      = CW'(d);
        bus.high_len   = CW'(h);
        bus.low_len    = CW'(l);
        bus.num_pulses = NW'(n);
        bus.start      = st;
        bus.abort      = ab;
    endtask

    // Timeline of a train accepted at edge t0, from the pulse rules alone.
    task automatic model_start(input int t0, input int d, input int h, input int l, input int n);
        int h1, l1, r, t_end;
        h1 = (h == 0) ? 1 : h;
        l1 = (l == 0) ? 1 : l;
        for (int t = t0; t < MAXC; t++) begin
            exp_wave[t] = 1'b0;
            exp_busy[t] = 1'b0;
            exp_done[t] = 1'b0;
        end
        if (n == 0) begin
            if (t0 + 1 < MAXC) exp_done[t0 + 1] = 1'b1;
            return;
        end
        r = t0 + d + 1;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < h1; k++)
                if (r + k < MAXC) exp_wave[r + k] = 1'b1;
            r += h1 + l1;
        end
        t_end = t0 + d + 1 + n * h1 + (n - 1) * l1;
        for (int t = t0; t < t_end && t < MAXC; t++) exp_busy[t] = 1'b1;
        if (t_end < MAXC) exp_done[t_end] = 1'b1;
    endtask

    task automatic model_cancel(input int ta);
        for (int t = ta; t < MAXC; t++) begin
            exp_wave[t] = 1'b0;
            exp_busy[t] = 1'b0;
            exp_done[t] = 1'b0;
        end
    endtask

    task automatic start_train(input int d, input int h, input int l, input int n,
                               input bit hold, output int t0);
        apply_stimulus(d, h, l, n, 1'b1, 1'b0);
        t0 = cyc + 1;
        model_start(t0, d, h, l, n);
        step();
        if (!hold) apply_stimulus(9, 9, 9, 9, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            check_output($sformatf("wave@%0d", cyc), {31'd0, bus.wave}, {31'd0, exp_wave[cyc]});
            check_output($sformatf("rise@%0d", cyc), {31'd0, bus.rise_strobe},
                         {31'd0, exp_wave[cyc] && !exp_wave[cyc - 1]});
            check_output($sformatf("busy@%0d", cyc), {31'd0, bus.busy}, {31'd0, exp_busy[cyc]});
            check_output($sformatf("done@%0d", cyc), {31'd0, bus.done}, {31'd0, exp_done[cyc]});
            if (bus.rise_strobe === 1'b1) dut_rise_cnt++;
            if (bus.wave === 1'b1 && prev_wave !== 1'b1) wave_edge_cnt++;
            if (bus.done === 1'b1) begin
                dut_done_cnt++;
                last_done_cyc = cyc;
            end
            prev_wave = bus.wave;
        end
    end

    initial begin
        int t0, ta, tr, t_end, base, model_rises;

        apply_stimulus(0, 0, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check_output("reset_wave", {31'd0, bus.wave}, 32'd0);
        check_output("reset_rise", {31'd0, bus.rise_strobe}, 32'd0);
        check_output("reset_busy", {31'd0, bus.busy}, 32'd0);
        check_output("reset_done", {31'd0, bus.done}, 32'd0);
        step();

        // delay=3 high=2 low=1 three pulses; inputs scrambled and start re-pulsed mid-train
        base = dut_rise_cnt;
        start_train(3, 2, 1, 3, 1'b0, t0);
        model_rises = 0;
        for (int t = t0; t <= t0 + 13; t++)
            if (exp_wave[t] && !exp_wave[t - 1]) model_rises++;
        check_output("A_model_rises", model_rises, 32'd3);
        check_output("A_model_done", {31'd0, exp_done[t0 + 12]}, 32'd1);
        wait_until(t0 + 3);
        check_output("A_wave_e3", {31'd0, bus.wave}, 32'd0);
        wait_until(t0 + 4);
        check_output("A_wave_e4", {31'd0, bus.wave}, 32'd1);
        check_output("A_rise_e4", {31'd0, bus.rise_strobe}, 32'd1);
        wait_until(t0 + 5);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_until(t0 + 7);
        check_output("A_wave_e7", {31'd0, bus.wave}, 32'd1);
        wait_until(t0 + 10);
        check_output("A_wave_e10", {31'd0, bus.wave}, 32'd1);
        wait_until(t0 + 13);
        check_output("A_done_cycle", last_done_cyc - t0, 32'd12);
        check_output("A_rise_count", dut_rise_cnt - base, 32'd3);

        // zero lengths behave as one cycle
        start_train(0, 0, 0, 2, 1'b0, t0);
        wait_until(t0 + 1);
        check_output("B_wave_e1", {31'd0, bus.wave}, 32'd1);
        wait_until(t0 + 2);
        check_output("B_wave_e2", {31'd0, bus.wave}, 32'd0);
        wait_until(t0 + 3);
        check_output("B_wave_e3", {31'd0, bus.wave}, 32'd1);
        wait_until(t0 + 5);
        check_output("B_done_cycle", last_done_cyc - t0, 32'd4);

        // empty train
        start_train(5, 3, 3, 0, 1'b0, t0);
        check_output("C_busy_e0", {31'd0, bus.busy}, 32'd0);
        wait_until(t0 + 2);
        check_output("C_done_cycle", last_done_cyc - t0, 32'd1);
        check_output("C_wave", {31'd0, bus.wave}, 32'd0);

        // abort during the second high phase, then restart immediately
        start_train(2, 3, 2, 3, 1'b0, t0);
        wait_until(t0 + 8);
        check_output("D_wave_2nd_high", {31'd0, bus.wave}, 32'd1);
        base = dut_done_cnt;
        bus.abort = 1'b1;
        step();
        ta = cyc;
        model_cancel(ta);
        bus.abort = 1'b0;
        check_output("D_wave_after_abort", {31'd0, bus.wave}, 32'd0);
        check_output("D_busy_after_abort", {31'd0, bus.busy}, 32'd0);
        start_train(1, 1, 1, 1, 1'b0, t0);
        wait_until(ta + 5);
        check_output("D_done_count", dut_done_cnt - base, 32'd1);
        check_output("D_restart_done", last_done_cyc - ta, 32'd4);

        // abort beats start while idle
        apply_stimulus(0, 1, 1, 1, 1'b1, 1'b1);
        step();
        apply_stimulus(0, 1, 1, 1, 1'b0, 1'b0);
        step();
        check_output("E_busy", {31'd0, bus.busy}, 32'd0);
        check_output("E_wave", {31'd0, bus.wave}, 32'd0);

        // start held through the done cycle gives a back-to-back second train
        base = dut_rise_cnt;
        start_train(1, 2, 2, 2, 1'b1, t0);
        t_end = t0 + 8;
        wait_until(t_end);
        check_output("F_done_first", {31'd0, bus.done}, 32'd1);
        apply_stimulus(0, 1, 1, 1, 1'b1, 1'b0);
        model_start(t_end + 1, 0, 1, 1, 1);
        step();
        apply_stimulus(0, 0, 0, 0, 1'b0, 1'b0);
        wait_until(t_end + 2);
        check_output("F_second_rise", {31'd0, bus.rise_strobe}, 32'd1);
        wait_until(t_end + 4);
        check_output("F_done_second", last_done_cyc - t_end, 32'd3);
        check_output("F_rise_count", dut_rise_cnt - base, 32'd3);
        check_output("F_edges_vs_strobes", wave_edge_cnt, dut_rise_cnt);

        // maximum delay gives exactly 255 delay cycles
        start_train(255, 1, 1, 1, 1'b0, t0);
        wait_until(t0 + 255);
        check_output("H_wave_e255", {31'd0, bus.wave}, 32'd0);
        wait_until(t0 + 256);
        check_output("H_wave_e256", {31'd0, bus.wave}, 32'd1);
        wait_until(t0 + 258);
        check_output("H_done_cycle", last_done_cyc - t0, 32'd257);

        // reset in the middle of a long delay
        start_train(255, 1, 1, 3, 1'b0, t0);
        wait_until(t0 + 10);
        check_output("G_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        step();
        tr = cyc;
        model_cancel(tr);
        rst = 1'b0;
        check_output("G_wave", {31'd0, bus.wave}, 32'd0);
        check_output("G_busy", {31'd0, bus.busy}, 32'd0);
        check_output("G_done", {31'd0, bus.done}, 32'd0);
        check_output("G_rise", {31'd0, bus.rise_strobe}, 32'd0);
        base = wave_edge_cnt;
        repeat (300) step();
        check_output("G_no_edges", wave_edge_cnt - base, 32'd0);
        check_output("final_edges_vs_strobes", wave_edge_cnt, dut_rise_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
